// File: rtl/fifo_read_drain.sv
// Read-side drain for the synchronous FIFO: streams words through a 2-entry skid
// or flushes them. Optional rd_count port under FIFO_READ_DRAIN_STATS_EN.
module fifo_read_drain #(
    parameter int FIFO_WIDTH = 16,
    parameter int SKID_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  flush,
    input  logic                  empty,
    input  logic                  underflow,
    input  logic [FIFO_WIDTH-1:0] data_out,
    output logic                  rd_en,
    output logic                  m_valid,
    output logic [FIFO_WIDTH-1:0] m_data,
    input  logic                  m_ready,
    output logic                  flush_done,
    output logic                  busy,
    output logic                  err_underflow
`ifdef FIFO_READ_DRAIN_STATS_EN
    ,
    output logic [15:0]           rd_count
`endif
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] FLUSH = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    generate
        if (SKID_DEPTH != 2) begin : g_bad_depth
            $error("fifo_read_drain: SKID_DEPTH must be 2");
        end
    endgenerate

    logic [1:0]            state;
    logic [1:0]            state_nxt;
    logic [1:0]            count;
    logic                  inflight;
    logic [FIFO_WIDTH-1:0] skid0;
    logic [FIFO_WIDTH-1:0] skid1;
    logic                  pop;
    logic [2:0]            occ;

    assign m_valid    = (state != FLUSH) && (count != 2'd0);
    assign m_data     = skid0;
    assign pop        = m_valid && m_ready;
    assign flush_done = (state == DONE);
    assign busy       = (state == FLUSH) ||
                        ((state == RUN) && (inflight || count != 2'd0));

    // Occupancy after this edge; a read is only issued when a slot is guaranteed.
    assign occ = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};

    always_comb begin
        rd_en = 1'b0;
        unique case (state)
            RUN:     rd_en = !empty && enable && (occ < 3'd2);
            FLUSH:   rd_en = !empty;
            IDLE:    rd_en = 1'b0;
            DONE:    rd_en = 1'b0;
        endcase
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (flush)       state_nxt = FLUSH;
                else if (enable) state_nxt = RUN;
            end
            RUN: begin
                if (flush)
                    state_nxt = FLUSH;
                else if (!enable && !inflight && count == 2'd0)
                    state_nxt = IDLE;
            end
            FLUSH: begin
                if (empty && !inflight) state_nxt = DONE;
            end
            DONE: begin
                state_nxt = flush ? FLUSH : IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            inflight      <= 1'b0;
            err_underflow <= 1'b0;
        end else begin
            state    <= state_nxt;
            inflight <= rd_en && !empty;
            if (underflow)
                err_underflow <= 1'b1;
        end
    end

    // Skid is a 2-deep shift queue; skid0 is always the head.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= 2'd0;
            skid0 <= '0;
            skid1 <= '0;
        end else if (state == FLUSH) begin
            count <= 2'd0;
        end else begin
            unique case ({inflight, pop})
                2'b11: begin
                    if (count == 2'd2) begin
                        skid0 <= skid1;
                        skid1 <= data_out;
                    end else begin
                        skid0 <= data_out;
                    end
                end
                2'b10: begin
                    if (count == 2'd0)
                        skid0 <= data_out;
                    else
                        skid1 <= data_out;
                    count <= count + 2'd1;
                end
                2'b01: begin
                    skid0 <= skid1;
                    count <= count - 2'd1;
                end
                2'b00: begin
                    count <= count;
                end
            endcase
        end
    end

`ifdef FIFO_READ_DRAIN_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            rd_count <= 16'd0;
        else if (pop)
            rd_count <= rd_count + 16'd1;
    end
`endif

endmodule

// File: tb/tb_fifo_read_drain.sv
// Scoreboard bench for fifo_read_drain: behavioural FIFO, expected-word queue,
// negedge monitor, directed plus randomized traffic.
module tb_fifo_read_drain;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         enable = 1'b0;
    logic         flush = 1'b0;
    logic         m_ready = 1'b0;
    logic         empty;
    logic         underflow;
    logic [W-1:0] data_out = '0;
    logic         rd_en;
    logic         m_valid;
    logic [W-1:0] m_data;
    logic         flush_done;
    logic         busy;
    logic         err_underflow;
`ifdef FIFO_READ_DRAIN_STATS_EN
    logic [15:0]  rd_count;
`endif

    fifo_read_drain #(.FIFO_WIDTH(W), .SKID_DEPTH(2)) dut (
        .clk           (clk),
        .rst           (rst),
        .enable        (enable),
        .flush         (flush),
        .empty         (empty),
        .underflow     (underflow),
        .data_out      (data_out),
        .rd_en         (rd_en),
        .m_valid       (m_valid),
        .m_data        (m_data),
        .m_ready       (m_ready),
        .flush_done    (flush_done),
        .busy          (busy),
        .err_underflow (err_underflow)
`ifdef FIFO_READ_DRAIN_STATS_EN
        ,
        .rd_count      (rd_count)
`endif
    );

    always #5 clk = ~clk;

    // Behavioural FIFO: pend[rp..wp-1] holds the stored words.
    logic [W-1:0] pend [0:4095];
    int           wp = 0;
    int           rp = 0;
    logic         uf_model = 1'b0;
    logic         uf_force = 1'b0;

    assign empty     = (rp == wp);
    assign underflow = uf_model | uf_force;

    always @(posedge clk) begin
        uf_model <= rd_en && (rp == wp);
        if (rd_en && rp != wp) begin
            data_out <= pend[rp];
            rp       <= rp + 1;
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input bit ok, input string name,
                       input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    // Reference model: the stream is the pushed words in order, minus flushed ones.
    logic [W-1:0] exp_q [$];
    logic [W-1:0] exp_e;
    int           ndeliv = 0;
    int           ndone  = 0;
    logic         pv = 1'b0;
    logic         pr = 1'b0;
    logic         pf = 1'b0;
    logic [W-1:0] pd = '0;

    always @(negedge clk) begin
        if (rst) begin
            pv = 1'b0;
            pr = 1'b0;
            pf = 1'b0;
        end else begin
            chk(!(rd_en && empty), "rd_en_while_empty", 32'(rd_en), 0);
            if (pv && !pr && !pf && !flush)
                chk(m_valid && m_data == pd, "stream_hold",
                    {15'd0, m_valid, m_data}, {15'd0, 1'b1, pd});
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    chk(1'b0, "unexpected_word", 32'(m_data), 0);
                end else begin
                    exp_e = exp_q.pop_front();
                    chk(m_data == exp_e, "stream_data", 32'(m_data), 32'(exp_e));
                end
                ndeliv++;
            end
            if (flush_done)
                ndone++;
            pv = m_valid;
            pr = m_ready;
            pf = flush;
            pd = m_data;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [W-1:0] v);
        pend[wp] = v;
        wp = wp + 1;
        exp_q.push_back(v);
    endtask

    task automatic drain(input int budget, input string name);
        int n;
        n = 0;
        while (!(exp_q.size() == 0 && rp == wp && !busy) && n < budget) begin
            tick();
            n++;
        end
        chk(n < budget, name, 32'(n), 32'(budget));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int nrd;
        int n;
        int base;
        int dbase;
        int fr;
        int fv;
        int lr;
        int lv;
        logic rdh [0:15];
        logic vh  [0:15];
`ifdef FIFO_READ_DRAIN_STATS_EN
        logic [15:0] rc0;
`endif

        // Reset held with words waiting and the sink ready.
        rst = 1'b1;
        enable = 1'b1;
        m_ready = 1'b1;
        for (int i = 0; i < 3; i++) push(16'hA001 + 16'(i));
        repeat (4) begin
            @(negedge clk);
            chk(rd_en == 1'b0, "reset_rd_en", 32'(rd_en), 0);
            chk(m_valid == 1'b0, "reset_m_valid", 32'(m_valid), 0);
            chk(busy == 1'b0, "reset_busy", 32'(busy), 0);
        end
        chk(m_data == '0, "reset_m_data", 32'(m_data), 0);
        chk(flush_done == 1'b0, "reset_flush_done", 32'(flush_done), 0);
        chk(err_underflow == 1'b0, "reset_err", 32'(err_underflow), 0);
        tick();
        rst = 1'b0;
        drain(50, "reset_words_drain");

        // Full-rate streaming of 8 preloaded words.
        enable = 1'b0;
        repeat (3) tick();
`ifdef FIFO_READ_DRAIN_STATS_EN
        rc0 = rd_count;
`endif
        for (int i = 0; i < 8; i++) push(16'(i + 1));
        enable = 1'b1;
        m_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            rdh[i] = rd_en;
            vh[i]  = m_valid;
        end
        fr = -1; fv = -1; lr = 0; lv = 0; nrd = 0;
        for (int i = 0; i < 16; i++) begin
            if (rdh[i]) nrd++;
            if (rdh[i] && fr < 0) fr = i;
            if (vh[i] && fv < 0) fv = i;
        end
        for (int i = 0; i < 16; i++) begin
            if (fr >= 0 && i >= fr && i < fr + 8 && rdh[i]) lr++;
            if (fv >= 0 && i >= fv && i < fv + 8 && vh[i]) lv++;
        end
        chk(nrd == 8 && lr == 8, "stream_rd_run", 32'(lr), 8);
        chk(lv == 8, "stream_valid_run", 32'(lv), 8);
        chk(fr >= 0 && fv - fr == 2, "stream_latency", 32'(fv - fr), 2);
        tick();
        chk(exp_q.size() == 0, "stream_all_delivered", 32'(exp_q.size()), 0);
`ifdef FIFO_READ_DRAIN_STATS_EN
        chk(rd_count - rc0 == 16'd8, "stream_rd_count", 32'(rd_count - rc0), 8);
`endif

        // Backpressure: only two reads fit while the sink stalls.
        m_ready = 1'b0;
        for (int i = 0; i < 4; i++) push(16'(i + 1));
        nrd = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (rd_en) nrd++;
        end
        chk(nrd == 2, "bp_reads", 32'(nrd), 2);
        chk(m_valid == 1'b1, "bp_valid", 32'(m_valid), 1);
        chk(m_data == 16'h0001, "bp_head", 32'(m_data), 1);
        tick();
        m_ready = 1'b1;
        drain(40, "bp_drain");

        // Trickle input: FIFO frequently empty.
        for (int i = 0; i < 8; i++) begin
            push(16'h5500 + 16'(i));
            repeat (3) tick();
        end
        drain(40, "trickle_drain");
        chk(err_underflow == 1'b0, "trickle_no_underflow", 32'(err_underflow), 0);

        // Randomized traffic with random backpressure and enable drops.
        for (int i = 0; i < 400; i++) begin
            tick();
            if ($urandom_range(0, 99) < 55) push(16'($urandom));
            m_ready = ($urandom_range(0, 99) < 70);
            enable  = ($urandom_range(0, 99) < 90);
        end
        enable = 1'b1;
        m_ready = 1'b1;
        drain(400, "random_drain");

        // Flush mid-stream after two words delivered.
        enable = 1'b1;
        m_ready = 1'b0;
        for (int i = 0; i < 6; i++) push(16'hF000 + 16'(i));
        repeat (6) tick();
        base = ndeliv;
        m_ready = 1'b1;
        n = 0;
        while (ndeliv - base < 2 && n < 20) begin
            tick();
            n++;
        end
        chk(n < 20, "flush_pre_deliver", 32'(ndeliv - base), 2);
        m_ready = 1'b0;
        enable = 1'b0;
        flush = 1'b1;
        exp_q.delete();
        dbase = ndone;
        tick();
        flush = 1'b0;
        m_ready = 1'b1;
        chk(m_valid == 1'b0, "flush_valid_drop", 32'(m_valid), 0);
        chk(busy == 1'b1, "flush_busy", 32'(busy), 1);
        n = 0;
        while (ndone == dbase && n < 40) begin
            tick();
            n++;
        end
        chk(n < 40, "flush_done_seen", 32'(n), 40);
        repeat (5) tick();
        chk(ndone - dbase == 1, "flush_done_once", 32'(ndone - dbase), 1);
        chk(empty == 1'b1, "flush_fifo_empty", 32'(empty), 1);
        chk(busy == 1'b0, "flush_idle_busy", 32'(busy), 0);
        chk(ndeliv - base == 2, "flush_no_extra", 32'(ndeliv - base), 2);
`ifdef FIFO_READ_DRAIN_STATS_EN
        chk(rd_count == 16'(ndeliv), "total_rd_count", 32'(rd_count), 32'(ndeliv));
`endif

        // Sticky underflow, cleared only by an asynchronous reset.
        uf_force = 1'b1;
        tick();
        uf_force = 1'b0;
        chk(err_underflow == 1'b1, "uf_set", 32'(err_underflow), 1);
        repeat (5) tick();
        chk(err_underflow == 1'b1, "uf_sticky", 32'(err_underflow), 1);
        #2;
        rst = 1'b1;
        #1;
        chk(err_underflow == 1'b0, "uf_async_clear", 32'(err_underflow), 0);
        chk(m_valid == 1'b0 && busy == 1'b0, "async_reset_outputs",
            {30'd0, m_valid, busy}, 0);
`ifdef FIFO_READ_DRAIN_STATS_EN
        chk(rd_count == 16'd0, "async_reset_rd_count", 32'(rd_count), 0);
`endif
        tick();
        rst = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
